data_bus_interface: RTL and testbench

DATA_BUS_INTERFACE -- requirements
Module: data_bus_interface

---
 rtl/dbi_pkg.sv | 17 +
 rtl/data_bus_interface.sv | 141 ++++++++++++++
 tb/tb_data_bus_interface.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dbi_pkg.sv
// Shared types and constants for the external data bus interface.
// Widths here are the defaults for data_bus_interface.
package dbi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } dbi_state_e;

  localparam int   DBI_WIDTH      = 8;
  localparam int   DBI_ADDR_WIDTH = 16;
  localparam int   DBI_RST_ADDR   = 0;
  localparam logic DBI_RST_RW     = 1'b1;

endpackage

// File: rtl/data_bus_interface.sv
// Four-phase external bus master: IDLE, SETUP, ACCESS, HOLD.
// Define DBI_RDY_WAIT_EN to let reads stall on rdy and expose stall_cnt.
module data_bus_interface
  import dbi_pkg::*;
#(
  parameter int WIDTH      = DBI_WIDTH,
  parameter int ADDR_WIDTH = DBI_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ack,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  rw_out,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rdy
`ifdef DBI_RDY_WAIT_EN
  ,
  output logic [7:0]            stall_cnt
`endif
);

  dbi_state_e            r_state, w_state_n;
  logic                  r_we, w_we_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic                  r_rw, w_rw_n;
  logic [WIDTH-1:0]      r_dout, w_dout_n;
  logic                  r_den, w_den_n;
  logic [WIDTH-1:0]      r_rdata, w_rdata_n;
  logic                  r_ack, w_ack_n;
  logic                  r_busy, w_busy_n;
  logic                  w_go;

`ifdef DBI_RDY_WAIT_EN
  logic [7:0] r_stall, w_stall_n;
  assign w_go = r_we | rdy;
`else
  // rdy has no effect in this build; ACCESS is always one cycle
  assign w_go = rdy | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= ADDR_WIDTH'(DBI_RST_ADDR);
      r_rw    <= DBI_RST_RW;
      r_dout  <= '0;
      r_den   <= 1'b0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DBI_RDY_WAIT_EN
      r_stall <= 8'd0;
`endif
    end else begin
      r_state <= w_state_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_rw    <= w_rw_n;
      r_dout  <= w_dout_n;
      r_den   <= w_den_n;
      r_rdata <= w_rdata_n;
      r_ack   <= w_ack_n;
      r_busy  <= w_busy_n;
`ifdef DBI_RDY_WAIT_EN
      r_stall <= w_stall_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_rw_n    = r_rw;
    w_dout_n  = r_dout;
    w_den_n   = r_den;
    w_rdata_n = r_rdata;
    w_ack_n   = 1'b0;
`ifdef DBI_RDY_WAIT_EN
    w_stall_n = r_stall;
`endif
    unique case (r_state)
      IDLE: begin
        if (req) begin
          w_state_n = SETUP;
          w_we_n    = we;
          w_addr_n  = addr;
          w_rw_n    = ~we;
          if (we) w_dout_n = wdata;
`ifdef DBI_RDY_WAIT_EN
          w_stall_n = 8'd0;
`endif
        end
      end
      SETUP: begin
        w_state_n = ACCESS;
        w_den_n   = r_we;
      end
      ACCESS: begin
        if (w_go) begin
          w_state_n = HOLD;
          w_ack_n   = 1'b1;
          if (!r_we) w_rdata_n = din;
        end
`ifdef DBI_RDY_WAIT_EN
        else if (r_stall != 8'hFF) begin
          w_stall_n = r_stall + 8'd1;
        end
`endif
      end
      HOLD: begin
        w_state_n = IDLE;
        w_den_n   = 1'b0;
        w_rw_n    = DBI_RST_RW;
      end
      default: w_state_n = IDLE;
    endcase
    w_busy_n = (w_state_n != IDLE);
  end

  assign rdata    = r_rdata;
  assign ack      = r_ack;
  assign busy     = r_busy;
  assign addr_out = r_addr;
  assign rw_out   = r_rw;
  assign dout     = r_dout;
  assign dout_en  = r_den;
`ifdef DBI_RDY_WAIT_EN
  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_data_bus_interface.sv
// Randomized bench for data_bus_interface against a transaction model.
// Model tracks each access by its accept cycle and its completion cycle.
module tb_data_bus_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  din = '0;
  logic        rdy = 1'b1;
  logic [7:0]  rdata;
  logic        ack;
  logic        busy;
  logic [15:0] addr_out;
  logic        rw_out;
  logic [7:0]  dout;
  logic        dout_en;
`ifdef DBI_RDY_WAIT_EN
  logic [7:0]  stall_cnt;
`endif

  data_bus_interface dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .addr_out (addr_out),
    .rw_out   (rw_out),
    .dout     (dout),
    .dout_en  (dout_en),
    .din      (din),
    .rdy      (rdy)
`ifdef DBI_RDY_WAIT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model of the access in flight
  int          cyc = 0;
  bit          m_act = 0;
  int          m_start = 0;
  int          m_ack_cyc = -1;
  bit          m_we = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_dout = '0;
  logic [7:0]  m_rdata = '0;
  int          m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    bit a;
    a = m_act;
    chk("busy", busy, a);
    chk("ack", ack, a && m_ack_cyc == cyc);
    chk("dout_en", dout_en, a && m_we && (cyc - m_start) >= 2);
    chk("rw_out", rw_out, !(a && m_we));
    chk("addr_out", addr_out, m_addr);
    chk("dout", dout, m_dout);
    chk("rdata", rdata, m_rdata);
`ifdef DBI_RDY_WAIT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic model_reset();
    m_act = 0; m_ack_cyc = -1; m_we = 0;
    m_addr = '0; m_dout = '0; m_rdata = '0; m_stall = 0;
  endtask

  // applied with the inputs seen at the edge that ends cycle cyc
  task automatic model_edge();
    bit stall_ok;
`ifdef DBI_RDY_WAIT_EN
    stall_ok = 1;
`else
    stall_ok = 0;
`endif
    if (!m_act) begin
      if (req) begin
        m_act = 1; m_start = cyc; m_ack_cyc = -1;
        m_we = we; m_addr = addr; m_stall = 0;
        if (we) m_dout = wdata;
      end
    end else if (m_ack_cyc == cyc) begin
      m_act = 0;
    end else if (cyc - m_start >= 2 && m_ack_cyc < 0) begin
      if (m_we || rdy || !stall_ok) begin
        m_ack_cyc = cyc + 1;
        if (!m_we) m_rdata = din;
      end else if (m_stall < 255) begin
        m_stall++;
      end
    end
  endtask

  task automatic step(input logic q, input logic w, input logic [15:0] a,
                      input logic [7:0] wd, input logic [7:0] di,
                      input logic r);
    @(negedge clk);
    check_all();
    req = q; we = w; addr = a; wdata = wd; din = di; rdy = r;
    @(posedge clk);
    model_edge();
    cyc++;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;

    // directed read, write, then a stalled read
    step(1, 0, 16'h1234, 8'h00, 8'hA5, 1);
    repeat (4) step(0, 0, 16'h0000, 8'h00, 8'hA5, 1);
    step(1, 1, 16'hFFFE, 8'h3C, 8'h11, 0);
    repeat (4) step(0, 0, 16'h0000, 8'h00, 8'h22, 0);
    step(1, 0, 16'h0042, 8'h00, 8'h33, 0);
    repeat (4) step(0, 0, 16'h0000, 8'h00, 8'h44, 0);
    repeat (3) step(0, 0, 16'h0000, 8'h00, 8'h5A, 1);

    // req held high, alternating direction
    for (int i = 0; i < 16; i++)
      step(1, i[0], 16'(16'h0100 + i), 8'(i * 3), 8'(8'hC0 + i), 1);

    // reset in ACCESS of a write
    step(0, 0, 16'h0, 8'h0, 8'h0, 1);
    repeat (4) step(0, 0, 16'h0, 8'h0, 8'h0, 1);
    step(1, 1, 16'hBEEF, 8'h77, 8'h00, 1);
    step(0, 0, 16'h0, 8'h0, 8'h00, 1);
    @(negedge clk);
    check_all();
    chk("dout_en_pre_rst", dout_en, 1);
    #1 rst_n = 1'b0;
    #1 model_reset();
    chk("dout_en_async", dout_en, 0);
    chk("busy_async", busy, 0);
    chk("ack_async", ack, 0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    step(1, 0, 16'h0ABC, 8'h00, 8'h96, 1);
    repeat (4) step(0, 0, 16'h0, 8'h00, 8'h96, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
           16'($urandom), 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1);

    @(negedge clk);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
